serial_digit_adder: RTL and testbench



---
 rtl/serial_digit_adder_pkg.sv | 15 +
 rtl/serial_digit_adder_digit_adder.sv | 48 ++++
 rtl/serial_digit_adder.sv | 136 +++++++++++++
 tb/tb_serial_digit_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the multi-cycle digit-serial adder/subtractor.
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-digit configuration still needs a 1-bit index register.
    function automatic int idx_width(input int num_digits);
        return (num_digits <= 2) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// Half-adder cell and the combinational DIGIT-bit ripple adder built from it.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);
    logic [DIGIT:0]   carry;
    logic [DIGIT-1:0] prop;
    logic [DIGIT-1:0] gen_ab;
    logic [DIGIT-1:0] gen_pc;

    assign carry[0] = c_in;

    // Full adder per bit: two half adders, carries merged with OR.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        half_adder u_ha_ab (
            .a_i (a_d[i]),
            .b_i (b_d[i]),
            .s_o (prop[i]),
            .c_o (gen_ab[i])
        );
        half_adder u_ha_pc (
            .a_i (prop[i]),
            .b_i (carry[i]),
            .s_o (s_d[i]),
            .c_o (gen_pc[i])
        );
        assign carry[i+1] = gen_ab[i] | gen_pc[i];
    end

    assign c_out    = carry[DIGIT];
    assign c_msb_in = carry[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed DIGIT bits per clock
// with a registered carry, wrapped in input and output valid/ready handshakes.
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int NUM_DIGITS = WIDTH / DIGIT_SAFE;
    localparam int IDX_W      = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if ((DIGIT < 1) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_param_check
        $error("serial_digit_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             dig_c_out;
    logic             dig_c_msb;

    assign a_dig = a_q[idx_q*DIGIT +: DIGIT];
    assign b_dig = b_q[idx_q*DIGIT +: DIGIT];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a_d      (a_dig),
        .b_d      (b_dig),
        .c_in     (carry_q),
        .s_d      (s_dig),
        .c_out    (dig_c_out),
        .c_msb_in (dig_c_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*DIGIT +: DIGIT] = s_dig;
                carry_d = dig_c_out;
                if (idx_q == LAST_IDX) begin
                    c_out_d = dig_c_out;
                    ovf_d   = dig_c_msb ^ dig_c_out;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed and randomised checks of serial_digit_adder at DIGIT = 4, 1 and 16.
module tb_serial_digit_adder;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    logic [2:0]        in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf;
    logic [2:0][W-1:0] a, b, sum;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(W), .DIGIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0])
    );

    serial_digit_adder #(.WIDTH(W), .DIGIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1])
    );

    serial_digit_adder #(.WIDTH(W), .DIGIT(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2])
    );

    function automatic int num_digits(input int k);
        case (k)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Reference result {ovf, c_out, sum} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
        logic [16:0] t;
        logic        ov;
        if (s) t = {1'b0, x} - {1'b0, y} + 17'h10000;
        else   t = {1'b0, x} + {1'b0, y};
        if (s) ov = (x[15] != y[15]) && (t[15] != x[15]);
        else   ov = (x[15] == y[15]) && (t[15] != x[15]);
        return {ov, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Issue one operation on DUT k; returns the cycle index in which out_valid is seen.
    task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, output int cyc);
        int guard;
        guard = 0;
        while (!in_ready[k] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a[k] = av; b[k] = bv; sub[k] = sv; in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        cyc = 1;
        while (!out_valid[k] && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic op_check(input string tag, input int k, input logic [15:0] av,
                            input logic [15:0] bv, input logic sv);
        int          cyc;
        logic [17:0] r;
        r = ref_op(av, bv, sv);
        do_op(k, av, bv, sv, cyc);
        check({tag, "_sum"}, 32'(sum[k]), 32'(r[15:0]));
        check({tag, "_cout"}, 32'(c_out[k]), 32'(r[16]));
        check({tag, "_ovf"}, 32'(ovf[k]), 32'(r[17]));
        check({tag, "_lat"}, 32'(cyc), 32'(num_digits(k) + 1));
    endtask

    initial begin
        int cyc;
        int seen;
        int guard;
        logic [15:0] ra, rb;
        logic        rs;

        in_valid = '0; sub = '0; out_ready = '1; a = '0; b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_sum", 32'(sum[0]), 32'd0);
        check("rst_cout", 32'(c_out[0]), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, DIGIT = 4: sum, c_out, ovf and latency 5
        op_check("add_1234_4321", 0, 16'h1234, 16'h4321, 1'b0);
        op_check("add_ffff_0001", 0, 16'hFFFF, 16'h0001, 1'b0);
        op_check("add_7fff_0001", 0, 16'h7FFF, 16'h0001, 1'b0);
        op_check("sub_0005_0007", 0, 16'h0005, 16'h0007, 1'b1);
        op_check("sub_8000_0001", 0, 16'h8000, 16'h0001, 1'b1);
        check("abs_sum_7fff", 32'(sum[0]), 32'h7FFF);
        check("abs_ovf_8000m1", 32'(ovf[0]), 32'd1);

        // Let the last result handshake, then hold off the consumer
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        a[0] = 16'h1111; b[0] = 16'h2222; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        a[0] = 16'hFFFF; b[0] = 16'hFFFF; sub[0] = 1'b1; in_valid[0] = 1'b1;
        check("run_in_ready", 32'(in_ready[0]), 32'd0);
        guard = 0;
        while (!out_valid[0] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_sum", 32'(sum[0]), 32'h3333);
        check("bp_cout", 32'(c_out[0]), 32'd0);
        check("bp_ovf", 32'(ovf[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_sum", 32'(sum[0]), 32'h3333);
            check("hold_out_valid", 32'(out_valid[0]), 32'd1);
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_hs_out_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("next_accept", 32'(in_ready[0]), 32'd0);
        guard = 0;
        while (!out_valid[0] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("sub_ffff_ffff_sum", 32'(sum[0]), 32'h0000);
        check("sub_ffff_ffff_cout", 32'(c_out[0]), 32'd1);
        check("sub_ffff_ffff_ovf", 32'(ovf[0]), 32'd0);
        @(posedge clk); #1;

        // Reset during the second RUN cycle
        a[0] = 16'h1234; b[0] = 16'h1111; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_sum", 32'(sum[0]), 32'd0);
        check("mid_rst_cout", 32'(c_out[0]), 32'd0);
        @(negedge clk) reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            seen += int'(out_valid[0]);
        end
        check("mid_rst_no_valid", 32'(seen), 32'd0);
        op_check("after_rst_1p1", 0, 16'h0001, 16'h0001, 1'b0);

        // Parameter sweep: bit-serial and single-cycle instances
        for (int k = 1; k < 3; k++) begin
            op_check("sweep_edge_ovf", k, 16'h7FFF, 16'h0001, 1'b0);
            op_check("sweep_edge_sub", k, 16'h8000, 16'h0001, 1'b1);
            repeat (200) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                op_check((k == 1) ? "sweep_d1" : "sweep_d16", k, ra, rb, rs);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
